// File: rtl/ila_trace_buffer_if.sv
// ---------------------------------------------------------------------------
// ila_trace_buffer_if : trace beat stream (tdata/tvalid/tready/tlast)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ila_trace_buffer_if;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;

  modport master (
    output m_tdata,
    output m_tvalid,
    output m_tlast,
    input  m_tready
  );

  modport slave (
    input  m_tdata,
    input  m_tvalid,
    input  m_tlast,
    output m_tready
  );
endinterface

`default_nettype wire

// File: rtl/ila_trace_buffer.sv
// ---------------------------------------------------------------------------
// ila_trace_buffer : per-hart commit-trace FIFO, 3-beat stream serialiser.
// Optional PC trigger gating via macro ILA_TRACE_TRIGGER_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ila_trace_buffer #(
  parameter int DEPTH = 16
) (
  input  logic                    coreclk,
  input  logic                    corerstn,
  input  logic                    trace_en,
  input  logic [1:0]              ila_hartid,
  input  logic [31:0]             ila_csr_time,
  input  logic [39:0]             ila_pc,
  input  logic                    ila_instr_valid,
  input  logic [31:0]             ila_instr,
  input  logic                    ila_rd_wen,
  input  logic [4:0]              ila_rd_waddr,
  input  logic [63:0]             ila_rd_wdata,
`ifdef ILA_TRACE_TRIGGER_EN
  input  logic [39:0]             trig_pc,
`endif
  ila_trace_buffer_if.master      m_axis,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [15:0]             drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_B0   = 2'd1;
  localparam logic [1:0] S_B1   = 2'd2;
  localparam logic [1:0] S_B2   = 2'd3;

  logic [191:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   drop_q, drop_d;
  logic [1:0]    state_q, state_d;
  logic [127:0]  rec_q, rec_d;
  logic [63:0]   tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d;
  logic          tlast_q, tlast_d;

  logic          w_armed;
  logic          w_capture;
  logic          w_full;
  logic          w_empty;
  logic          w_wr;
  logic          w_pop;
  logic          w_hs;
  logic [191:0]  w_rec;
  logic [191:0]  w_head;

`ifdef ILA_TRACE_TRIGGER_EN
  logic armed_q;
  logic w_hit;

  // The triggering commit is captured in the same cycle the trigger fires.
  assign w_hit   = ila_instr_valid && trace_en && (ila_pc == trig_pc);
  assign w_armed = armed_q || w_hit;

  always_ff @(posedge coreclk or negedge corerstn) begin
    if (!corerstn) armed_q <= 1'b0;
    else if (w_hit) armed_q <= 1'b1;
  end
`else
  assign w_armed = 1'b1;
`endif

  assign w_capture = ila_instr_valid && trace_en && w_armed;
  assign w_full    = (count_q == CW'(DEPTH));
  assign w_empty   = (count_q == '0);
  assign w_wr      = w_capture && !w_full;
  assign w_hs      = tvalid_q && m_axis.m_tready;

  assign w_rec = {(ila_rd_wen ? ila_rd_wdata : 64'h0),
                  ila_csr_time, ila_instr,
                  ila_hartid, ila_rd_wen, ila_rd_waddr, 16'h0, ila_pc};
  assign w_head = mem_q[rd_ptr_q];

  always_ff @(posedge coreclk) begin
    if (w_wr) mem_q[wr_ptr_q] <= w_rec;
  end

  always_comb begin
    state_d  = state_q;
    rec_d    = rec_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    w_pop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop    = 1'b1;
          rec_d    = w_head[191:64];
          tdata_d  = w_head[63:0];
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          state_d  = S_B0;
        end
      end
      S_B0: begin
        if (w_hs) begin
          tdata_d = rec_q[63:0];
          state_d = S_B1;
        end
      end
      S_B1: begin
        if (w_hs) begin
          tdata_d = rec_q[127:64];
          tlast_d = 1'b1;
          state_d = S_B2;
        end
      end
      S_B2: begin
        if (w_hs) begin
          tlast_d = 1'b0;
          if (!w_empty) begin
            w_pop   = 1'b1;
            rec_d   = w_head[191:64];
            tdata_d = w_head[63:0];
            state_d = S_B0;
          end else begin
            tvalid_d = 1'b0;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Full check uses the pre-cycle count, so a same-cycle pop never rescues a write.
  always_comb begin
    count_d = count_q + CW'(w_wr) - CW'(w_pop);
    drop_d  = drop_q;
    if (w_capture && w_full && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge coreclk or negedge corerstn) begin
    if (!corerstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      state_q  <= S_IDLE;
      rec_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      if (w_wr)  wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q  <= count_d;
      drop_q   <= drop_d;
      state_q  <= state_d;
      rec_q    <= rec_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

  assign m_axis.m_tdata  = tdata_q;
  assign m_axis.m_tvalid = tvalid_q;
  assign m_axis.m_tlast  = tlast_q;
  assign fifo_count      = count_q;
  assign drop_cnt        = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_ila_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_ila_trace_buffer : directed self-checking bench for ila_trace_buffer.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ila_trace_buffer;

  logic        coreclk = 1'b0;
  logic        corerstn;
  logic        trace_en;
  logic [1:0]  ila_hartid;
  logic [31:0] ila_csr_time;
  logic [39:0] ila_pc;
  logic        ila_instr_valid;
  logic [31:0] ila_instr;
  logic        ila_rd_wen;
  logic [4:0]  ila_rd_waddr;
  logic [63:0] ila_rd_wdata;
  logic [39:0] trig_pc;
  logic [4:0]  fifo_count;
  logic [15:0] drop_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  ila_trace_buffer_if trace_if ();

  ila_trace_buffer #(.DEPTH(16)) dut (
    .coreclk         (coreclk),
    .corerstn        (corerstn),
    .trace_en        (trace_en),
    .ila_hartid      (ila_hartid),
    .ila_csr_time    (ila_csr_time),
    .ila_pc          (ila_pc),
    .ila_instr_valid (ila_instr_valid),
    .ila_instr       (ila_instr),
    .ila_rd_wen      (ila_rd_wen),
    .ila_rd_waddr    (ila_rd_waddr),
    .ila_rd_wdata    (ila_rd_wdata),
`ifdef ILA_TRACE_TRIGGER_EN
    .trig_pc         (trig_pc),
`endif
    .m_axis          (trace_if.master),
    .fifo_count      (fifo_count),
    .drop_cnt        (drop_cnt)
  );

  always #5 coreclk = ~coreclk;

  task automatic tick();
    @(negedge coreclk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic commit(input logic [1:0] hart, input logic wen, input logic [4:0] waddr,
                        input logic [39:0] pc, input logic [31:0] t,
                        input logic [31:0] instr, input logic [63:0] wdata);
    ila_hartid      = hart;
    ila_rd_wen      = wen;
    ila_rd_waddr    = waddr;
    ila_pc          = pc;
    ila_csr_time    = t;
    ila_instr       = instr;
    ila_rd_wdata    = wdata;
    ila_instr_valid = 1'b1;
  endtask

  // Back-to-back records k=0..2: hart 3, wen 1, waddr 1, pc 0x1000+4k, time 0x10+k, wdata k+1
  function automatic logic [63:0] b2b_beat(input int i);
    int k = i / 3;
    case (i % 3)
      0:       return 64'hE100_0000_0000_1000 + 64'(4 * k);
      1:       return 64'h0000_0010_0000_0013 + (64'(k) << 32);
      default: return 64'(k + 1);
    endcase
  endfunction

  initial begin
    corerstn        = 1'b0;
    trace_en        = 1'b1;
    ila_instr_valid = 1'b0;
    ila_hartid      = '0;
    ila_csr_time    = '0;
    ila_pc          = '0;
    ila_instr       = '0;
    ila_rd_wen      = 1'b0;
    ila_rd_waddr    = '0;
    ila_rd_wdata    = '0;
    trig_pc         = 40'h00_8000_0100;
    trace_if.m_tready = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_tvalid", 64'(trace_if.m_tvalid), 64'd0);
    chk("rst_tlast",  64'(trace_if.m_tlast),  64'd0);
    chk("rst_tdata",  trace_if.m_tdata,       64'd0);
    chk("rst_count",  64'(fifo_count),        64'd0);
    chk("rst_drop",   64'(drop_cnt),          64'd0);
    corerstn = 1'b1;
    tick();

`ifndef ILA_TRACE_TRIGGER_EN
    // Single record: beats in N+2..N+4
    commit(2'd1, 1'b1, 5'd5, 40'h00_8000_0000, 32'd7, 32'h0000_0013, 64'hDEAD_BEEF);
    tick();
    ila_instr_valid = 1'b0;
    chk("single_count_written", 64'(fifo_count), 64'd1);
    chk("single_tvalid_n1", 64'(trace_if.m_tvalid), 64'd0);
    tick();
    chk("single_tvalid_b0", 64'(trace_if.m_tvalid), 64'd1);
    chk("single_beat0", trace_if.m_tdata, 64'h6500_0000_8000_0000);
    chk("single_tlast_b0", 64'(trace_if.m_tlast), 64'd0);
    chk("single_count_popped", 64'(fifo_count), 64'd0);
    tick();
    chk("single_beat1", trace_if.m_tdata, 64'h0000_0007_0000_0013);
    tick();
    chk("single_beat2", trace_if.m_tdata, 64'h0000_0000_DEAD_BEEF);
    chk("single_tlast_b2", 64'(trace_if.m_tlast), 64'd1);
    tick();
    chk("single_idle", 64'(trace_if.m_tvalid), 64'd0);

    // Backpressure during beat1 (rd_wen=0 -> beat2 is zero)
    commit(2'd2, 1'b0, 5'd31, 40'h12_3456_7890, 32'h100, 32'hAABB_CCDD, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    ila_instr_valid = 1'b0;
    tick();
    chk("bp_beat0", trace_if.m_tdata, 64'h9F00_0012_3456_7890);
    tick();
    chk("bp_beat1", trace_if.m_tdata, 64'h0000_0100_AABB_CCDD);
    trace_if.m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_tdata",  trace_if.m_tdata, 64'h0000_0100_AABB_CCDD);
      chk("bp_hold_tvalid", 64'(trace_if.m_tvalid), 64'd1);
      chk("bp_hold_tlast",  64'(trace_if.m_tlast), 64'd0);
    end
    trace_if.m_tready = 1'b1;
    tick();
    chk("bp_beat2", trace_if.m_tdata, 64'd0);
    chk("bp_tlast", 64'(trace_if.m_tlast), 64'd1);
    tick();
    chk("bp_idle", 64'(trace_if.m_tvalid), 64'd0);

    // Back-to-back records, gap-free
    commit(2'd3, 1'b1, 5'd1, 40'h1000, 32'h10, 32'h13, 64'd1);
    tick();
    commit(2'd3, 1'b1, 5'd1, 40'h1004, 32'h11, 32'h13, 64'd2);
    tick();
    chk("b2b_tvalid", 64'(trace_if.m_tvalid), 64'd1);
    chk("b2b_tdata",  trace_if.m_tdata, b2b_beat(0));
    chk("b2b_tlast",  64'(trace_if.m_tlast), 64'd0);
    chk("b2b_sim_wr_pop_count", 64'(fifo_count), 64'd1);
    commit(2'd3, 1'b1, 5'd1, 40'h1008, 32'h12, 32'h13, 64'd3);
    tick();
    ila_instr_valid = 1'b0;
    chk("b2b_tdata",  trace_if.m_tdata, b2b_beat(1));
    for (int i = 2; i < 9; i++) begin
      tick();
      chk("b2b_tvalid", 64'(trace_if.m_tvalid), 64'd1);
      chk("b2b_tdata",  trace_if.m_tdata, b2b_beat(i));
      chk("b2b_tlast",  64'(trace_if.m_tlast), 64'((i % 3) == 2));
    end
    tick();
    chk("b2b_idle", 64'(trace_if.m_tvalid), 64'd0);

    // Overflow: record 0 sits in the serialiser, 16 more fill the FIFO, 3 drop
    trace_if.m_tready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      commit(2'd0, 1'b0, 5'd0, 40'h20_0000_0000 + 40'(4 * k), 32'(k), 32'h13, 64'd0);
      tick();
      chk("ovf_count", 64'(fifo_count), (k == 0) ? 64'd1 : ((k > 16) ? 64'd16 : 64'(k)));
      chk("ovf_drop",  64'(drop_cnt),   (k > 16) ? 64'(k - 16) : 64'd0);
    end
    ila_instr_valid = 1'b0;
    chk("ovf_hold_beat0", trace_if.m_tdata, 64'h0000_0020_0000_0000);
    trace_if.m_tready = 1'b1;
    tick();
    chk("ovf_r0_beat1_valid", 64'(trace_if.m_tvalid), 64'd1);
    tick();
    chk("ovf_r0_tlast", 64'(trace_if.m_tlast), 64'd1);
    // Commit coincides with the pop from a full FIFO: still dropped
    commit(2'd0, 1'b0, 5'd0, 40'hFF_FFFF_FFF0, 32'd0, 32'h13, 64'd0);
    tick();
    ila_instr_valid = 1'b0;
    chk("ovf_pop_no_rescue_drop",  64'(drop_cnt),   64'd4);
    chk("ovf_pop_no_rescue_count", 64'(fifo_count), 64'd15);
    for (int b = 0; b < 48; b++) begin
      chk("drain_tvalid", 64'(trace_if.m_tvalid), 64'd1);
      chk("drain_tlast",  64'(trace_if.m_tlast), 64'((b % 3) == 2));
      if ((b % 3) == 0)
        chk("drain_pc", 64'(trace_if.m_tdata[39:0]), 64'h20_0000_0000 + 64'(4 * (1 + b / 3)));
      tick();
    end
    chk("drain_idle",  64'(trace_if.m_tvalid), 64'd0);
    chk("drain_count", 64'(fifo_count), 64'd0);

    // trace_en low blocks capture
    trace_en = 1'b0;
    commit(2'd0, 1'b0, 5'd0, 40'h3000, 32'd0, 32'h13, 64'd0);
    tick();
    ila_instr_valid = 1'b0;
    chk("disabled_count", 64'(fifo_count), 64'd0);
    tick();
    chk("disabled_tvalid", 64'(trace_if.m_tvalid), 64'd0);
    trace_en = 1'b1;

    // Mid-stream reset during beat1
    trace_if.m_tready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      commit(2'd1, 1'b0, 5'd0, 40'h4000 + 40'(4 * k), 32'd0, 32'h13, 64'd0);
      tick();
    end
    ila_instr_valid = 1'b0;
    trace_if.m_tready = 1'b1;
    tick();
    trace_if.m_tready = 1'b0;
    chk("mrst_pre_beat1", trace_if.m_tdata, 64'h0000_0000_0000_0013);
    chk("mrst_pre_count", 64'(fifo_count), 64'd2);
    #2 corerstn = 1'b0;
    #1;
    chk("mrst_tvalid_async", 64'(trace_if.m_tvalid), 64'd0);
    chk("mrst_tdata",  trace_if.m_tdata, 64'd0);
    chk("mrst_count",  64'(fifo_count), 64'd0);
    chk("mrst_drop",   64'(drop_cnt), 64'd0);
    tick();
    corerstn = 1'b1;
    trace_if.m_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mrst_no_beats", 64'(trace_if.m_tvalid), 64'd0);
      chk("mrst_count_after", 64'(fifo_count), 64'd0);
    end
`else
    // Trigger: only commits from the trigger PC onward are recorded
    commit(2'd0, 1'b0, 5'd0, 40'h00_8000_0000, 32'd0, 32'h13, 64'd0);
    tick();
    chk("trig_pre_count", 64'(fifo_count), 64'd0);
    commit(2'd0, 1'b0, 5'd0, 40'h00_8000_0100, 32'd1, 32'h13, 64'd0);
    tick();
    chk("trig_hit_count", 64'(fifo_count), 64'd1);
    chk("trig_hit_tvalid", 64'(trace_if.m_tvalid), 64'd0);
    commit(2'd0, 1'b0, 5'd0, 40'h00_8000_0104, 32'd2, 32'h13, 64'd0);
    tick();
    ila_instr_valid = 1'b0;
    chk("trig_r0_beat0", trace_if.m_tdata, 64'h0000_0000_8000_0100);
    tick();
    chk("trig_r0_beat1", trace_if.m_tdata, 64'h0000_0001_0000_0013);
    tick();
    chk("trig_r0_tlast", 64'(trace_if.m_tlast), 64'd1);
    tick();
    chk("trig_r1_beat0", trace_if.m_tdata, 64'h0000_0000_8000_0104);
    tick();
    chk("trig_r1_beat1", trace_if.m_tdata, 64'h0000_0002_0000_0013);
    tick();
    chk("trig_r1_tlast", 64'(trace_if.m_tlast), 64'd1);
    tick();
    chk("trig_idle", 64'(trace_if.m_tvalid), 64'd0);
    chk("trig_count", 64'(fifo_count), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
